// File: rtl/gift_scheduler_pkg.sv
// Shared types and game constants for the gift scheduler and its powerup timer.
// Random-bit indices define the meaning of each bit sampled before a spawn.
package gift_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_SELECT = 2'd2,
    ST_SPAWN  = 2'd3
  } sched_state_e;

  localparam int NUM_SLOTS_DEF = 3;

  localparam int RB_LOCATION = 0;
  localparam int RB_TYPE     = 1;
  localparam int RB_SKIP     = 2;

  localparam int FRAME_CNT_W_DEF    = 10;
  localparam int SPAWN_INTERVAL_DEF = 180;
  localparam int POWERUP_FRAMES_DEF = 600;
  localparam int RAND_BITS_DEF      = 3;

  // Width of a slot index; a single slot still needs one bit to be addressable.
  function automatic int slot_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gift_scheduler_if.sv
// Bundle between the scheduler and the gift instances: slot status in, spawn command out.
// master = scheduler side, slave = gift-instance side.
interface gift_scheduler_if
  import gift_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF
);

  logic [NUM_SLOTS-1:0] slot_active;
  logic [NUM_SLOTS-1:0] slot_collected;
  logic [NUM_SLOTS-1:0] slot_is_powerup;
  logic [NUM_SLOTS-1:0] spawn_req;
  logic                 spawn_location;
  logic                 spawn_powerup;

  modport master (
    input  slot_active,
    input  slot_collected,
    input  slot_is_powerup,
    output spawn_req,
    output spawn_location,
    output spawn_powerup
  );

  modport slave (
    output slot_active,
    output slot_collected,
    output slot_is_powerup,
    input  spawn_req,
    input  spawn_location,
    input  spawn_powerup
  );

endinterface

// File: rtl/gift_scheduler_powerup_timer.sv
// Frame-based powerup countdown: a load restarts the full duration, each tick counts down.
// Reusable by any powerup source; active drops in the same cycle the count reaches zero.
module gift_scheduler_powerup_timer
  import gift_scheduler_pkg::*;
#(
  parameter int CNT_W       = FRAME_CNT_W_DEF,
  parameter int LOAD_FRAMES = POWERUP_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             tick_i,
  output logic             active_o,
  output logic [CNT_W-1:0] frames_left_o
);

  logic [CNT_W-1:0] left_q, left_d;
  logic             active_q, active_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q   <= '0;
      active_q <= 1'b0;
    end else begin
      left_q   <= left_d;
      active_q <= active_d;
    end
  end

  // Load has priority over the per-frame decrement and never accumulates.
  always_comb begin
    left_d   = left_q;
    active_d = active_q;
    if (en_i) begin
      if (load_i) begin
        left_d   = CNT_W'(LOAD_FRAMES);
        active_d = 1'b1;
      end else if (tick_i && (left_q != '0)) begin
        left_d = left_q - 1'b1;
        if (left_q == CNT_W'(1)) begin
          active_d = 1'b0;
        end
      end
    end
  end

  assign active_o      = active_q;
  assign frames_left_o = left_q;

endmodule

// File: rtl/gift_scheduler.sv
// Decides when, where and which type of gift spawns, round-robin over NUM_SLOTS instances,
// and runs the powerup timer triggered by collecting a powerup gift.
module gift_scheduler
  import gift_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS             = NUM_SLOTS_DEF,
  parameter int SPAWN_INTERVAL_FRAMES = SPAWN_INTERVAL_DEF,
  parameter int RAND_BITS             = RAND_BITS_DEF,
  parameter int POWERUP_FRAMES        = POWERUP_FRAMES_DEF,
  parameter int FRAME_CNT_W           = FRAME_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   enable,
  input  logic                   startOfFrame,
  input  logic                   random_bit,
  gift_scheduler_if.master       gifts,
  output logic                   powerup_active,
  output logic [FRAME_CNT_W-1:0] powerup_frames_left
);

  localparam int IW  = slot_idx_w(NUM_SLOTS);
  localparam int SCW = $clog2(RAND_BITS + 1);

  sched_state_e           state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SCW-1:0]         samp_cnt_q, samp_cnt_d;
  logic [RAND_BITS-1:0]   rbits_q, rbits_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          slot_idx_q, slot_idx_d;

  int                     search_start;
  logic [IW-1:0]          cand;
  logic                   found;
  logic [IW-1:0]          found_idx;
  logic [IW-1:0]          rr_next;
  logic                   spawn_now;
  logic [NUM_SLOTS-1:0]   spawn_req_v;
  logic                   pu_load;

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q     <= ST_WAIT;
      frame_cnt_q <= '0;
      samp_cnt_q  <= '0;
      rbits_q     <= '0;
      rr_ptr_q    <= '0;
      slot_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      rbits_q     <= rbits_d;
      rr_ptr_q    <= rr_ptr_d;
      slot_idx_q  <= slot_idx_d;
    end
  end

  // First free slot starting at the round-robin pointer, shifted by one when skip is set.
  always_comb begin
    found        = 1'b0;
    found_idx    = '0;
    cand         = '0;
    search_start = int'(rr_ptr_q) + int'(rbits_q[RB_SKIP]);
    for (int k = 0; k < NUM_SLOTS; k++) begin
      cand = IW'((search_start + k) % NUM_SLOTS);
      if (!found && !gifts.slot_active[cand]) begin
        found     = 1'b1;
        found_idx = cand;
      end
    end
  end

  assign rr_next = (slot_idx_q == IW'(NUM_SLOTS - 1)) ? '0 : slot_idx_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    rbits_d     = rbits_q;
    rr_ptr_d    = rr_ptr_q;
    slot_idx_d  = slot_idx_q;
    if (enable) begin
      case (state_q)
        ST_WAIT: begin
          if (startOfFrame) begin
            if (frame_cnt_q == FRAME_CNT_W'(SPAWN_INTERVAL_FRAMES - 1)) begin
              frame_cnt_d = '0;
              samp_cnt_d  = '0;
              state_d     = ST_SAMPLE;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        ST_SAMPLE: begin
          // Bit k of the sample word is the k-th bit taken after the interval ended.
          rbits_d[samp_cnt_q] = random_bit;
          if (samp_cnt_q == SCW'(RAND_BITS - 1)) begin
            state_d = ST_SELECT;
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
        ST_SELECT: begin
          if (found) begin
            slot_idx_d = found_idx;
            state_d    = ST_SPAWN;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_SPAWN: begin
          rr_ptr_d = rr_next;
          state_d  = ST_WAIT;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  assign spawn_now = enable && (state_q == ST_SPAWN);

  always_comb begin
    spawn_req_v = '0;
    if (spawn_now) begin
      spawn_req_v[slot_idx_q] = 1'b1;
    end
  end

  assign gifts.spawn_req      = spawn_req_v;
  assign gifts.spawn_location = spawn_now & rbits_q[RB_LOCATION];
  assign gifts.spawn_powerup  = spawn_now & rbits_q[RB_TYPE];

  assign pu_load = |(gifts.slot_collected & gifts.slot_is_powerup);

  gift_scheduler_powerup_timer #(
    .CNT_W       (FRAME_CNT_W),
    .LOAD_FRAMES (POWERUP_FRAMES)
  ) u_powerup_timer (
    .clk           (clk),
    .rst           (resetN),
    .en_i          (enable),
    .load_i        (pu_load),
    .tick_i        (startOfFrame),
    .active_o      (powerup_active),
    .frames_left_o (powerup_frames_left)
  );

endmodule

// File: tb/tb_gift_scheduler.sv
// Scoreboard bench for gift_scheduler: a reference model queues expected spawns as frames
// are driven; a negedge monitor pops and compares each spawn pulse, including its cycle.
module tb_gift_scheduler;

  localparam int NS  = 3;
  localparam int INT = 4;
  localparam int RB  = 3;
  localparam int PUF = 5;
  localparam int FW  = 10;

  logic          clk = 1'b0;
  logic          resetN;
  logic          enable;
  logic          sof;
  logic          random_bit;
  logic          powerup_active;
  logic [FW-1:0] powerup_frames_left;

  gift_scheduler_if #(.NUM_SLOTS(NS)) gif ();

  gift_scheduler #(
    .NUM_SLOTS             (NS),
    .SPAWN_INTERVAL_FRAMES (INT),
    .RAND_BITS             (RB),
    .POWERUP_FRAMES        (PUF),
    .FRAME_CNT_W           (FW)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .enable              (enable),
    .startOfFrame        (sof),
    .random_bit          (random_bit),
    .gifts               (gif),
    .powerup_active      (powerup_active),
    .powerup_frames_left (powerup_frames_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NS-1:0] req;
    logic          loc;
    logic          pu;
    int            stamp;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_fc   = 0;
  int            m_rr   = 0;
  int            m_left = 0;
  logic          m_act  = 1'b0;
  logic [NS-1:0] pu_v   = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (gif.spawn_req !== '0) begin
      if (exp_q.size() == 0) begin
        check("spawn_unexpected", 32'(gif.spawn_req), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("spawn_req",   32'(gif.spawn_req),      32'(e.req));
        check("spawn_loc",   32'(gif.spawn_location), 32'(e.loc));
        check("spawn_pu",    32'(gif.spawn_powerup),  32'(e.pu));
        check("spawn_cycle", 32'(cyc),                32'(e.stamp));
      end
    end
  end

  task automatic model_timer(input logic [NS-1:0] coll, input logic tick);
    if (enable) begin
      if ((coll & pu_v) != '0) begin
        m_left = PUF;
        m_act  = 1'b1;
      end else if (tick && m_left > 0) begin
        m_left--;
        if (m_left == 0) m_act = 1'b0;
      end
    end
  endtask

  task automatic model_frame(input logic [2:0] pat, input int edge_cyc);
    int   skip;
    int   s;
    logic hit;
    exp_t e;
    logic [NS-1:0] one;
    if (!enable) return;
    m_fc++;
    if (m_fc == INT) begin
      m_fc = 0;
      skip = int'(pat[2]);
      hit  = 1'b0;
      one  = 3'b001;
      for (int k = 0; k < NS; k++) begin
        s = (m_rr + skip + k) % NS;
        if (!hit && !gif.slot_active[s]) begin
          hit     = 1'b1;
          e.req   = one << s;
          e.loc   = pat[0];
          e.pu    = pat[1];
          e.stamp = edge_cyc + 4;
          exp_q.push_back(e);
          m_rr = (s + 1) % NS;
        end
      end
    end
  endtask

  task automatic check_timer(input string tag);
    check({tag, "_left"},   32'(powerup_frames_left), 32'(m_left));
    check({tag, "_active"}, 32'(powerup_active),      32'(m_act));
  endtask

  // One start-of-frame pulse (optionally with a collection), then the three sample-bit cycles
  // and enough idle time for any spawn to complete before the next frame.
  task automatic frame(input logic [2:0] pat, input logic [NS-1:0] coll);
    int edge_cyc;
    @(posedge clk); #1;
    sof = 1'b1;
    gif.slot_collected = coll;
    @(posedge clk); #1;
    sof = 1'b0;
    gif.slot_collected = '0;
    edge_cyc = cyc;
    random_bit = pat[0];
    model_timer(coll, 1'b1);
    model_frame(pat, edge_cyc);
    @(posedge clk); #1; random_bit = pat[1];
    @(posedge clk); #1; random_bit = pat[2];
    repeat (4) @(posedge clk);
    #1;
    check_timer("frame");
  endtask

  task automatic collect(input logic [NS-1:0] coll);
    @(posedge clk); #1;
    gif.slot_collected = coll;
    @(posedge clk); #1;
    gif.slot_collected = '0;
    model_timer(coll, 1'b0);
    check_timer("collect");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] pat;
    resetN = 1'b1;
    enable = 1'b0;
    sof = 1'b0;
    random_bit = 1'b0;
    gif.slot_active = '0;
    gif.slot_collected = '0;
    gif.slot_is_powerup = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_spawn_req", 32'(gif.spawn_req), 32'd0);
    check("rst_spawn_loc", 32'(gif.spawn_location), 32'd0);
    check("rst_spawn_pu",  32'(gif.spawn_powerup), 32'd0);
    check("rst_pu_active", 32'(powerup_active), 32'd0);
    check("rst_pu_left",   32'(powerup_frames_left), 32'd0);
    resetN = 1'b0;
    enable = 1'b1;

    // First interval: all zero bits, slot 0; second: all ones, skip to slot 2.
    repeat (INT) frame(3'b000, '0);
    repeat (INT) frame(3'b111, '0);
    check("rr_wrap_pending", 32'(exp_q.size()), 32'd0);

    // All slots busy: attempt dropped; then only slot 2 free.
    gif.slot_active = 3'b111;
    repeat (INT) frame(3'b111, '0);
    gif.slot_active = 3'b011;
    repeat (INT) frame(3'b010, '0);
    gif.slot_active = 3'b000;
    repeat (INT) frame(3'b101, '0);

    // Powerup: load, decrement, reload coincident with a frame, expire.
    gif.slot_is_powerup = 3'b010;
    pu_v = 3'b010;
    collect(3'b010);
    check("pu_load_left", 32'(powerup_frames_left), 32'd5);
    repeat (3) frame(3'b000, '0);
    check("pu_at_two", 32'(powerup_frames_left), 32'd2);
    frame(3'b000, 3'b010);
    check("pu_reload", 32'(powerup_frames_left), 32'd5);
    repeat (5) frame(3'($urandom_range(0, 7)), '0);
    check("pu_expired_left", 32'(powerup_frames_left), 32'd0);
    check("pu_expired_act",  32'(powerup_active), 32'd0);

    // Non-powerup collection leaves the timer alone; simultaneous collections load once.
    collect(3'b001);
    gif.slot_is_powerup = 3'b011;
    pu_v = 3'b011;
    collect(3'b011);
    frame(3'b000, '0);

    // Enable dropped mid-WAIT for 10 frames, with a powerup collection that must be ignored.
    frame(3'b000, '0);
    enable = 1'b0;
    repeat (5) frame(3'b111, '0);
    collect(3'b001);
    repeat (5) frame(3'b111, '0);
    check("dis_hold_left", 32'(powerup_frames_left), 32'd3);
    enable = 1'b1;
    repeat (2 * INT) begin
      pat = 3'($urandom_range(0, 7));
      frame(pat, '0);
    end

    // Reset during SAMPLE with a live powerup: everything clears, no spawn follows.
    while (m_fc != INT - 1) frame(3'b000, '0);
    collect(3'b010);
    @(posedge clk); #1;
    sof = 1'b1;
    random_bit = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    #1;
    check("rstmid_pu_active", 32'(powerup_active), 32'd0);
    check("rstmid_pu_left",   32'(powerup_frames_left), 32'd0);
    @(negedge clk);
    check("rstmid_spawn_req", 32'(gif.spawn_req), 32'd0);
    @(posedge clk); #1;
    resetN = 1'b0;
    m_fc = 0;
    m_rr = 0;
    m_left = 0;
    m_act = 1'b0;
    repeat (8) @(posedge clk);

    // Normal operation after reset, randomized bits.
    repeat (2 * INT) frame(3'($urandom_range(0, 7)), '0);

    repeat (6) @(posedge clk);
    check("spawns_outstanding", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gift_scheduler.md
Name: gift_scheduler

Overview:
- Frame-driven controller that decides when, in which slot, and of which type gifts enter play.
- Owns NUM_SLOTS gift instances: waits a frame interval, samples random bits, picks a free slot round-robin, issues a one-cycle spawn pulse with type.
- Also runs the powerup timer that follows collection of a powerup-type gift.
- Sits between the game-level controller and the gift instances; the GARO random source is external.

Parameters:
- NUM_SLOTS, 3, number of gift instances managed
- SPAWN_INTERVAL_FRAMES, 180, frames between spawn attempts
- RAND_BITS, 3, random bits sampled per spawn; bit0 = location, bit1 = type, bit2 = slot-skip
- POWERUP_FRAMES, 600, frames a powerup stays active after collection
- FRAME_CNT_W, 10, width of frame counters; must hold max(SPAWN_INTERVAL_FRAMES, POWERUP_FRAMES)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active-high (asserted = 1)
- enable  in  1  game running; 0 freezes all counters and the FSM
- startOfFrame  in  1  one-cycle pulse per video frame
- random_bit  in  1  free-running random bit, valid every cycle
- slot_active  in  NUM_SLOTS  1 = gift in slot is on screen
- slot_collected  in  NUM_SLOTS  one-cycle pulse: player took gift in slot
- slot_is_powerup  in  NUM_SLOTS  type of the gift currently held by each slot
- spawn_req  out  NUM_SLOTS  one-hot, one-cycle spawn command
- spawn_location  out  1  0 = initial X, 1 = alternative X; valid with spawn_req
- spawn_powerup  out  1  gift type; valid with spawn_req
- powerup_active  out  1  powerup currently in effect
- powerup_frames_left  out  FRAME_CNT_W  remaining powerup frames

Behaviour:
- Reset: FSM = WAIT; frame_cnt = 0; rr_ptr = 0; spawn_req = 0; spawn_location = 0; spawn_powerup = 0; powerup_active = 0; powerup_frames_left = 0.
- enable = 0: FSM, frame_cnt and powerup timer hold; spawn_req forced 0; no bit sampling.
- WAIT: frame_cnt increments on each startOfFrame.
  - Reaching SPAWN_INTERVAL_FRAMES-1 on a startOfFrame: frame_cnt -> 0, go to SAMPLE.
- SAMPLE: shift in random_bit once per clk for RAND_BITS cycles, then go to SELECT. Sampling is by clk, not by frame.
- SELECT (single cycle): search from rr_ptr, plus 1 if skip bit set, modulo NUM_SLOTS, for the first slot with slot_active = 0.
  - Found: latch slot index, go to SPAWN.
  - None free: drop the attempt, go to WAIT. No retry until the next interval.
- SPAWN (single cycle): spawn_req[idx] = 1, spawn_location = bit0, spawn_powerup = bit1. rr_ptr = idx+1 mod NUM_SLOTS. Next state WAIT.
- Spawn latency: from the interval-ending startOfFrame to spawn_req is exactly RAND_BITS+2 clk cycles.
- Powerup timer, independent of the FSM:
  - Any slot_collected[i] with slot_is_powerup[i] = 1 loads POWERUP_FRAMES and sets powerup_active = 1. This applies even when already active, with no accumulation.
  - Otherwise, on startOfFrame with frames_left > 0: decrement. Reaching 0 clears powerup_active in the same cycle.
  - Collection and startOfFrame in the same cycle: load wins.
  - Multiple simultaneous collections: a single load.
  - Non-powerup collections do not affect the timer.
- slot_collected while enable = 0 is ignored.
- Reset asserted mid-SAMPLE or mid-SPAWN: immediate return to reset values; no partial spawn pulse.

Decomposition:
- Shared package: FSM state enum (WAIT, SAMPLE, SELECT, SPAWN), NUM_SLOTS default, and the random-bit index constants (RB_LOCATION, RB_TYPE, RB_SKIP).
- FRAME_CNT_W and the interval/powerup defaults go with the other game constants.
- One natural sub-module: powerup_timer (load/decrement/active flag), reusable by other power-up sources.
- Slot search stays inline.

Test Plan:
- Reset, enable = 1, all slots free, random_bit = 0, SPAWN_INTERVAL_FRAMES = 4 -> spawn_req = 3'b001 exactly RAND_BITS+2 = 5 clk after the 4th startOfFrame; location = 0, powerup = 0.
- Next interval with random_bit = 1 -> skip bit set, search starts at slot 2 -> spawn_req = 3'b100, location = 1, powerup = 1; rr_ptr wraps to 0.
- slot_active = 3'b111 at SELECT -> no spawn_req pulse in that interval; FSM back in WAIT; next interval spawns normally once a slot frees.
- slot_collected = 3'b010 with slot_is_powerup = 3'b010, POWERUP_FRAMES = 5 -> powerup_active = 1, frames_left = 5, then decrementing per frame and reaching 0 / active = 0 after 5 startOfFrame pulses.
- Re-collection at frames_left = 2, coincident with startOfFrame -> frames_left = 5, not 4.
- enable dropped mid-WAIT for 10 frames -> frame_cnt and frames_left unchanged.
- Reset pulsed during SAMPLE -> all outputs 0 next cycle; no spawn_req.
